// File: rtl/pc_gen_if.sv
// Fetch handshake between the PC generator (master) and the fetch stage (slave).
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic            fetch_ready;

    modport master (output pc, output pc_valid, input fetch_ready);
    modport slave  (input pc, input pc_valid, output fetch_ready);
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for the rv32i front end.
// Boot address, fetch handshake, prioritised redirects (trap > branch > RAS pop
// > sequential), halt, misaligned-target rejection.
// Optional return-address stack is built when PC_RAS_EN is defined.
module pc_gen #(
    parameter int XLEN       = 32,
    parameter int INST_BYTES = 4,
    parameter int RAS_DEPTH  = 4,
    localparam int CW        = $clog2(RAS_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] boot_addr,
    pc_gen_if.master        fif,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            halt,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr,
    output logic [CW-1:0]   ras_count,
    output logic            ras_empty
);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] maddr_q, maddr_d;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] ras_top;
    logic            ras_flush, ras_do_push, ras_do_pop;

    assign pc_inc        = pc_q + XLEN'(INST_BYTES);
    assign fif.pc        = pc_q;
    assign fif.pc_valid  = (state_q == RUN);
    assign misalign      = misalign_q;
    assign misalign_addr = maddr_q;

    // State, pc and misalign registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= boot_addr & ALIGN_MASK;
            misalign_q <= 1'b0;
            maddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            maddr_q    <= maddr_d;
        end
    end

    // Next state and next pc by redirect priority; halt blocks sequential
    // advance and RAS activity in the cycle it is taken.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        misalign_d  = 1'b0;
        maddr_d     = maddr_q;
        ras_flush   = 1'b0;
        ras_do_push = 1'b0;
        ras_do_pop  = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN, HALT: begin
                if (trap) begin
                    state_d   = RUN;
                    pc_d      = trap_vec & ALIGN_MASK;
                    ras_flush = 1'b1;
                end else if (br_taken) begin
                    state_d = RUN;
                    if (br_target[1:0] == 2'b00) begin
                        pc_d = br_target;
                    end else begin
                        misalign_d = 1'b1;
                        maddr_d    = br_target;
                    end
                end else if (state_q == HALT) begin
                    state_d = HALT;
                end else if (halt) begin
                    state_d = HALT;
                end else if (fif.fetch_ready) begin
                    ras_do_push = ras_push;
                    ras_do_pop  = ras_pop;
                    if (ras_pop && !ras_empty) pc_d = ras_top;
                    else                       pc_d = pc_inc;
                end
            end
            default: state_d = BOOT;
        endcase
    end

`ifdef PC_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];
    logic [PW-1:0]   tp_q, tp_d, tp_inc;
    logic [CW-1:0]   cnt_q, cnt_d;

    assign tp_inc    = tp_q + PW'(1);
    assign ras_top   = ras_q[tp_q];
    assign ras_count = cnt_q;
    assign ras_empty = (cnt_q == '0);

    // Circular stack: tp points at the top entry; a full push overwrites the oldest.
    always_comb begin
        ras_d = ras_q;
        tp_d  = tp_q;
        cnt_d = cnt_q;
        if (ras_flush) begin
            cnt_d = '0;
        end else if (ras_do_push && ras_do_pop && !ras_empty) begin
            ras_d[tp_q] = pc_inc;
        end else if (ras_do_push) begin
            tp_d         = tp_inc;
            ras_d[tp_inc] = pc_inc;
            if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
        end else if (ras_do_pop && !ras_empty) begin
            tp_d  = tp_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tp_q  <= '0;
            cnt_q <= '0;
        end else begin
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
        end
    end

    // Stack storage; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (!reset) ras_q <= ras_d;
    end
`else
    logic unused_ras;

    assign ras_top    = '0;
    assign ras_count  = '0;
    assign ras_empty  = 1'b1;
    assign unused_ras = ras_flush ^ ras_do_push ^ ras_do_pop;
`endif

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator; successor to the single-register PC.
- Sits at the front of the rv32i datapath and feeds the fetch stage.
- Adds a runtime boot address, a fetch handshake, and prioritised redirects (trap, branch/jump, return prediction).
- Adds halt, misaligned-target detection, and an optional return-address stack (RAS).

Parameters:
XLEN, 32, address width in bits
INST_BYTES, 4, sequential increment in bytes
RAS_DEPTH, 4, RAS entries (power of 2, >=2); only meaningful with PC_RAS_EN
CW, $clog2(RAS_DEPTH+1), width of ras_count (derived, localparam)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high
boot_addr  in  XLEN  PC value loaded on reset
fetch_ready  in  1  fetch consumes current pc this cycle
br_taken  in  1  branch/jump redirect request
br_target  in  XLEN  redirect destination
trap  in  1  exception/interrupt redirect request
trap_vec  in  XLEN  trap handler address
halt  in  1  stop issuing PCs
ras_push  in  1  current pc is a call; push pc+INST_BYTES
ras_pop  in  1  current pc is a return; redirect to RAS top
pc  out  XLEN  current fetch address
pc_valid  out  1  pc is valid for fetch
misalign  out  1  one-cycle pulse: rejected misaligned target
misalign_addr  out  XLEN  offending target, held until next misalign
ras_count  out  CW  occupied RAS entries
ras_empty  out  1  ras_count==0

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk.
  - While reset is high: pc<=boot_addr with bits[1:0] forced to 0; pc_valid=0; misalign=0; misalign_addr=0; ras_count=0; state=BOOT.
  - Reset high mid-operation overrides every other input in that cycle.
- States:
  - BOOT: one cycle after reset release, pc_valid=0, pc held, then to RUN.
  - RUN: pc_valid=1.
  - HALT: pc_valid=0, pc held.
- Transitions:
  - RUN->HALT when halt=1 and neither trap nor br_taken is asserted.
  - HALT->RUN on trap or br_taken; the redirect is applied in the same edge.
  - halt is ignored in BOOT.
- RUN update priority, evaluated every cycle; fetch_ready is not required for redirects:
  1. trap: pc<=trap_vec&~3; RAS flushed (ras_count<=0).
  2. br_taken with br_target[1:0]==0: pc<=br_target.
  3. br_taken with br_target[1:0]!=0: pc unchanged; misalign=1 next cycle for exactly one cycle; misalign_addr<=br_target.
  4. fetch_ready & ras_pop & !ras_empty: pc<=RAS top; pop.
  5. fetch_ready: pc<=pc+INST_BYTES, modulo 2^XLEN (0xFFFFFFFC -> 0x00000000).
  6. Otherwise pc holds (stall).
- ras_push and ras_pop act only when fetch_ready=1, state=RUN, and no trap/br_taken in that cycle.
- Pop when empty: ignored; pc advances sequentially; ras_count stays 0.
- Push when full: circular overwrite of oldest entry; ras_count saturates at RAS_DEPTH.
- Simultaneous push+pop: pc<=old top; top entry replaced by pc+INST_BYTES; ras_count unchanged.
  - Empty case: push only, pc sequential.
- Push value is pc+INST_BYTES with the same wrap rule.
- Latency: every redirect is visible on pc one cycle after the request edge. No combinational path from inputs to pc.

Optional Feature:
PC_RAS_EN
- Defined: RAS storage (RAS_DEPTH x XLEN) and pointer logic are built as above.
- Undefined: no RAS storage; ras_push/ras_pop ignored (priority 4 never fires); ras_count=0; ras_empty=1.
- All other behaviour is identical.

Test Plan:
- Boot: boot_addr=0x00000103, reset 2 cycles, fetch_ready=1 -> pc=0x00000100, pc_valid=0 for BOOT cycle, then pc=0x100, 0x104, 0x108 with pc_valid=1.
- Stall/wrap: boot_addr=0xFFFFFFF8, fetch_ready 1,0,1,1 -> pc 0xFFFFFFF8, 0xFFFFFFFC, 0xFFFFFFFC, 0x00000000.
- Priority: in RUN at pc=0x200, trap=1 trap_vec=0x80, br_taken=1 br_target=0x400 same cycle -> next pc=0x80, ras_count=0; next cycle br_target=0x402 br_taken=1 -> pc stays 0x80, misalign=1 one cycle, misalign_addr=0x402.
- Halt: halt=1 at pc=0x10 -> pc_valid=0, pc held 3 cycles despite fetch_ready; br_taken to 0x40 -> pc=0x40, pc_valid=1 next cycle.
- RAS (PC_RAS_EN, RAS_DEPTH=4): push at pc 0x100, 0x200, 0x300, 0x400, 0x500 -> ras_count=4; pops return 0x504, 0x404, 0x304, 0x204; 5th pop with ras_empty=1 -> sequential pc.
- RAS push+pop and compile-out: ras_count=1 (top 0x104) at pc=0x300, ras_push=ras_pop=1 -> pc=0x104, top=0x304, ras_count=1; without PC_RAS_EN same stimulus -> pc=0x304, ras_empty=1.
